lcd_spi_sink: RTL and testbench
===============================

# lcd_spi_sink

Receiving end of the 4-wire SPI link that drives the 128x160 RGB565 panel. It oversamples the `sda`/`scl`/`cs`/`rs` lines on a local clock, decodes the command set our LCD driver emits (SLPOUT, CASET, RASET, RAMWR and friends), and turns RAMWR payload bytes into addressed pixel writes. It sits between the LCD pins and a framebuffer or VGA mirror, and serves as the in-simulation display model for the LCD driver.

## Interface
- `WIDTH`, default 128: panel columns; the column counter is $clog2(WIDTH) bits.
- `HEIGHT`, default 160: panel rows; the row counter is $clog2(HEIGHT) bits.
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth on each input pin (minimum 2).

Ports:
- `clk`  in  1  sampling clock; must run at least 4x the `scl` frequency.
- `reset`  in  1  reset, asynchronous, active-high.
- `scl`  in  1  SPI clock, idle low, mode 0.
- `sda`  in  1  SPI data, MSB first.
- `cs`  in  1  chip select, active low.
- `rs`  in  1  0 = command byte, 1 = data byte.
- `cmd_valid`  out  1  one-cycle pulse when a command byte is received.
- `cmd_byte`  out  8  last command byte; held until the next command.
- `pix_valid`  out  1  one-cycle pulse with a completed pixel.
- `pix_x`  out  $clog2(WIDTH)  pixel column.
- `pix_y`  out  $clog2(HEIGHT)  pixel row.
- `pix_data`  out  16  RGB565 pixel, first byte in [15:8].
- `frame_start`  out  1  one-cycle pulse on RAMWR (0x2C).
- `frame_done`  out  1  one-cycle pulse, coincident with `pix_valid`, for the pixel at (XE,YE).
- `sleeping`  out  1  1 after reset or SLPIN (0x10), 0 after SLPOUT (0x11).

## Operation
- Front end:
  - `scl`, `sda`, `cs` and `rs` pass through SYNC_STAGES synchronizers.
  - A rising-edge detect on synced `scl` while synced `cs`=0 shifts synced `sda` into an 8-bit shift register and increments a 3-bit bit counter.
  - On the 8th edge, the byte and `rs` (sampled at that edge) are latched and a one-cycle byte strobe fires. The bit counter returns to 0.
- Synced `cs`=1 clears the bit counter and discards any partial byte. Decoder state is kept across `cs` gaps, so `cs` may toggle per byte.
- Decoder FSM states: IDLE, CASET, RASET, RAMWR.
- On any command byte:
  - Pulse `cmd_valid` and update `cmd_byte`.
  - Clear the param index and discard any pending pixel high byte.
  - Transition:
    - 0x2A goes to CASET.
    - 0x2B goes to RASET.
    - 0x2C goes to RAMWR; load x<=XS, y<=YS; pulse `frame_start`.
    - 0x11 clears `sleeping`; 0x10 sets `sleeping`.
    - 0x01 (SWRESET) restores the window to full, sets `sleeping`=1, and goes to IDLE.
    - All other commands go to IDLE.
- CASET/RASET:
  - Take 4 data bytes: start hi, start lo, end hi, end lo, each as a 16-bit value. Extra data bytes are ignored.
  - The window registers update only when the 4th byte is received.
  - Clamp: end >= WIDTH (or HEIGHT) becomes WIDTH-1 (or HEIGHT-1); start > end becomes start = end. Start is truncated to the counter width after clamping.
- RAMWR:
  - Data bytes alternate high/low.
  - On the low byte, emit `pix_valid` with the current x/y, then advance the address.
- Address advance:
  - x == XE: x<=XS, y<=y+1.
  - At x == XE and y == YE: pulse `frame_done` and wrap to (XS,YS). The stream continues into the next frame without a new 0x2C.
- Data bytes in IDLE are ignored.
- Reset values:
  - Window XS=0, XE=WIDTH-1, YS=0, YE=HEIGHT-1.
  - FSM IDLE; x=y=0.
  - `cmd_byte`=0, `pix_data`=0, `pix_x`=0, `pix_y`=0.
  - All pulses 0; `sleeping`=1.
- Reset mid-byte or mid-frame aborts immediately. No pixel is emitted for a partial pair.

## Timing
- Byte strobe: SYNC_STAGES+1 clk cycles after the `clk` edge that first sees `scl` high on the pin for bit 0 (LSB).
- `cmd_valid`, `pix_valid`, `frame_start` and `frame_done` are registered, 1 cycle after the byte strobe. Total latency is SYNC_STAGES+2 cycles.
- `pix_x`/`pix_y`/`pix_data` are valid in the same cycle as `pix_valid` and hold until the next pixel.
- Window and address updates take effect before the next byte strobe. Back-to-back bytes (no `cs` gap) at clk/4 `scl` are supported with no loss.
- `cs` rising on the same cycle as the 8th `scl` edge: the byte is completed and accepted.

## Test plan
- **Reset defaults:** assert `reset` asynchronously mid-clock -> all outputs at their reset values; `sleeping`=1.
- **Sleep out:** send cmd 0x11 -> `cmd_valid` pulse, `cmd_byte`=0x11, `sleeping`=0.
- **Full-frame write:** send cmd 0x2C then data 0xF8,0x00 -> `frame_start`; then `pix_valid` with x=0, y=0, `pix_data`=0xF800.
- **Window wrap:** send CASET 0,2,0,3 and RASET 0,5,0,6, then 0x2C and 4 pixels -> addresses (2,5),(3,5),(2,6),(3,6); `frame_done` on the 4th; a 5th pixel goes to (2,5).
- **Clamping:** send CASET 0,200,0,250 -> XE=127, XS=127; every pixel lands at x=127.
- **Abort cases:**
  - `cs` high after 5 bits, then full byte 0x2C -> only 0x2C is decoded.
  - Odd byte followed by a command -> no pixel emitted.
  - Reset mid-RAMWR -> no `pix_valid`.

Source files
------------

// File: rtl/lcd_spi_sink.sv
// ---------------------------------------------------------------------------
// lcd_spi_sink : 4-wire SPI LCD receiver, decodes commands and RAMWR pixels.
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module lcd_spi_sink #(
  parameter int WIDTH       = 128,
  parameter int HEIGHT      = 160,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      scl,
  input  logic                      sda,
  input  logic                      cs,
  input  logic                      rs,
  output logic                      cmd_valid,
  output logic [7:0]                cmd_byte,
  output logic                      pix_valid,
  output logic [$clog2(WIDTH)-1:0]  pix_x,
  output logic [$clog2(HEIGHT)-1:0] pix_y,
  output logic [15:0]               pix_data,
  output logic                      frame_start,
  output logic                      frame_done,
  output logic                      sleeping
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  typedef enum logic [1:0] {ST_IDLE, ST_CASET, ST_RASET, ST_RAMWR} state_t;

  // Pin order in each stage: {scl, sda, cs, rs}
  logic [3:0] sync_q [SYNC_STAGES];
  logic       scl_s, sda_s, cs_s, rs_s;
  logic       scl_prev_q, rise_q, sda_p_q, rs_p_q;
  logic [6:0] shift_q;
  logic [2:0] bitcnt_q;
  logic       strobe_q, byte_rs_q;
  logic [7:0] byte_q;

  assign {scl_s, sda_s, cs_s, rs_s} = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0010;
      scl_prev_q <= 1'b0;
      rise_q     <= 1'b0;
      sda_p_q    <= 1'b0;
      rs_p_q     <= 1'b0;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      strobe_q   <= 1'b0;
      byte_rs_q  <= 1'b0;
      byte_q     <= '0;
    end else begin
      sync_q[0] <= {scl, sda, cs, rs};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      scl_prev_q <= scl_s;
      rise_q     <= scl_s & ~scl_prev_q & ~cs_s;
      sda_p_q    <= sda_s;
      rs_p_q     <= rs_s;
      strobe_q   <= 1'b0;
      // A pending edge wins over cs so a byte finishing as cs rises is kept
      if (rise_q) begin
        shift_q  <= {shift_q[5:0], sda_p_q};
        bitcnt_q <= bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          byte_q    <= {shift_q, sda_p_q};
          byte_rs_q <= rs_p_q;
          strobe_q  <= 1'b1;
        end
      end else if (cs_s) begin
        bitcnt_q <= '0;
      end
    end
  end

  state_t          state_q, state_d;
  logic [2:0]      pidx_q, pidx_d;
  logic [23:0]     p_q, p_d;
  logic            hi_pend_q, hi_pend_d;
  logic [7:0]      hi_q, hi_d;
  logic [XW-1:0]   xs_q, xs_d, xe_q, xe_d, x_q, x_d;
  logic [YW-1:0]   ys_q, ys_d, ye_q, ye_d, y_q, y_d;
  logic            cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d;
  logic            frame_start_q, frame_start_d, frame_done_q, frame_done_d;
  logic            sleeping_q, sleeping_d;
  logic [7:0]      cmd_byte_q, cmd_byte_d;
  logic [XW-1:0]   pix_x_q, pix_x_d;
  logic [YW-1:0]   pix_y_q, pix_y_d;
  logic [15:0]     pix_data_q, pix_data_d;
  logic [15:0]     lim, end_c;
  logic            start_gt;

  always_comb begin
    state_d       = state_q;
    pidx_d        = pidx_q;
    p_d           = p_q;
    hi_pend_d     = hi_pend_q;
    hi_d          = hi_q;
    xs_d          = xs_q;
    xe_d          = xe_q;
    ys_d          = ys_q;
    ye_d          = ye_q;
    x_d           = x_q;
    y_d           = y_q;
    cmd_valid_d   = 1'b0;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    sleeping_d    = sleeping_q;
    cmd_byte_d    = cmd_byte_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_data_d    = pix_data_q;

    // Clamp on the 4th parameter byte: end to the panel, then start to end
    lim      = (state_q == ST_CASET) ? 16'(WIDTH) : 16'(HEIGHT);
    end_c    = ({p_q[7:0], byte_q} >= lim) ? (lim - 16'd1) : {p_q[7:0], byte_q};
    start_gt = (p_q[23:8] > end_c);

    if (strobe_q && !byte_rs_q) begin
      cmd_valid_d = 1'b1;
      cmd_byte_d  = byte_q;
      pidx_d      = '0;
      hi_pend_d   = 1'b0;
      state_d     = ST_IDLE;
      case (byte_q)
        8'h2A: state_d = ST_CASET;
        8'h2B: state_d = ST_RASET;
        8'h2C: begin
          state_d       = ST_RAMWR;
          x_d           = xs_q;
          y_d           = ys_q;
          frame_start_d = 1'b1;
        end
        8'h11: sleeping_d = 1'b0;
        8'h10: sleeping_d = 1'b1;
        8'h01: begin
          xs_d       = '0;
          xe_d       = XW'(WIDTH - 1);
          ys_d       = '0;
          ye_d       = YW'(HEIGHT - 1);
          sleeping_d = 1'b1;
        end
        default: ;
      endcase
    end else if (strobe_q) begin
      case (state_q)
        ST_CASET, ST_RASET: begin
          if (pidx_q < 3'd4) begin
            pidx_d = pidx_q + 3'd1;
            p_d    = {p_q[15:0], byte_q};
            if (pidx_q == 3'd3) begin
              if (state_q == ST_CASET) begin
                xe_d = end_c[XW-1:0];
                xs_d = start_gt ? end_c[XW-1:0] : p_q[8 +: XW];
              end else begin
                ye_d = end_c[YW-1:0];
                ys_d = start_gt ? end_c[YW-1:0] : p_q[8 +: YW];
              end
            end
          end
        end
        ST_RAMWR: begin
          if (!hi_pend_q) begin
            hi_pend_d = 1'b1;
            hi_d      = byte_q;
          end else begin
            hi_pend_d   = 1'b0;
            pix_valid_d = 1'b1;
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            pix_data_d  = {hi_q, byte_q};
            if (x_q == xe_q) begin
              x_d = xs_q;
              if (y_q == ye_q) begin
                y_d          = ys_q;
                frame_done_d = 1'b1;
              end else begin
                y_d = y_q + YW'(1);
              end
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pidx_q        <= '0;
      p_q           <= '0;
      hi_pend_q     <= 1'b0;
      hi_q          <= '0;
      xs_q          <= '0;
      xe_q          <= XW'(WIDTH - 1);
      ys_q          <= '0;
      ye_q          <= YW'(HEIGHT - 1);
      x_q           <= '0;
      y_q           <= '0;
      cmd_valid_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      sleeping_q    <= 1'b1;
      cmd_byte_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      pidx_q        <= pidx_d;
      p_q           <= p_d;
      hi_pend_q     <= hi_pend_d;
      hi_q          <= hi_d;
      xs_q          <= xs_d;
      xe_q          <= xe_d;
      ys_q          <= ys_d;
      ye_q          <= ye_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cmd_valid_q   <= cmd_valid_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      sleeping_q    <= sleeping_d;
      cmd_byte_q    <= cmd_byte_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_data_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign sleeping    = sleeping_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_spi_sink.sv
// ---------------------------------------------------------------------------
// tb_lcd_spi_sink : scoreboard bench driving SPI command/pixel streams.
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lcd_spi_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        scl = 1'b0, sda = 1'b0, cs = 1'b1, rs = 1'b0;
  logic        cmd_valid, pix_valid, frame_start, frame_done, sleeping;
  logic [7:0]  cmd_byte;
  logic [6:0]  pix_x;
  logic [7:0]  pix_y;
  logic [15:0] pix_data;

  lcd_spi_sink #(.WIDTH(128), .HEIGHT(160), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .cs(cs), .rs(rs),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .frame_done(frame_done), .sleeping(sleeping)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cv;
    logic [7:0]  cb;
    logic        pv;
    logic [6:0]  x;
    logic [7:0]  y;
    logic [15:0] d;
    logic        fs;
    logic        fd;
    logic        sl;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic sleep_m = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic exp_cmd(input logic [7:0] b);
    ev_t e;
    if (b == 8'h11) sleep_m = 1'b0;
    if (b == 8'h10 || b == 8'h01) sleep_m = 1'b1;
    e = '0;
    e.cv = 1'b1; e.cb = b; e.fs = (b == 8'h2C); e.sl = sleep_m;
    exp_q.push_back(e);
  endtask

  task automatic exp_pix(input logic [6:0] x, input logic [7:0] y,
                         input logic [15:0] d, input logic fd);
    ev_t e;
    e = '0;
    e.pv = 1'b1; e.x = x; e.y = y; e.d = d; e.fd = fd; e.sl = sleep_m;
    exp_q.push_back(e);
  endtask

  // n bits of b, MSB first, scl at clk/4
  task automatic send(input logic r, input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk); cs = 1'b0; rs = r; sda = b[i]; scl = 1'b0;
      @(negedge clk);
      @(negedge clk); scl = 1'b1;
      @(negedge clk);
    end
    @(negedge clk); scl = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] b);
    exp_cmd(b);
    send(1'b0, b, 8);
  endtask

  task automatic dat(input logic [7:0] b);
    send(1'b1, b, 8);
  endtask

  task automatic pix(input logic [6:0] x, input logic [7:0] y,
                     input logic [15:0] d, input logic fd);
    send(1'b1, d[15:8], 8);
    exp_pix(x, y, d, fd);
    send(1'b1, d[7:0], 8);
  endtask

  // Monitor: pops one expected event per output pulse
  always @(negedge clk) begin
    if (!reset && (cmd_valid || pix_valid || frame_start || frame_done)) begin
      ev_t a, e;
      a = '0;
      a.cv = cmd_valid;  a.cb = cmd_valid ? cmd_byte : 8'h00;
      a.pv = pix_valid;
      a.x  = pix_valid ? pix_x : 7'h0;
      a.y  = pix_valid ? pix_y : 8'h0;
      a.d  = pix_valid ? pix_data : 16'h0;
      a.fs = frame_start; a.fd = frame_done; a.sl = sleeping;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cv=%0b cb=%0h pv=%0b x=%0d y=%0d d=%0h fs=%0b fd=%0b, expected none",
                 a.cv, a.cb, a.pv, a.x, a.y, a.d, a.fs, a.fd);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL event: got cv=%0b cb=%0h pv=%0b x=%0d y=%0d d=%0h fs=%0b fd=%0b sl=%0b, expected cv=%0b cb=%0h pv=%0b x=%0d y=%0d d=%0h fs=%0b fd=%0b sl=%0b",
                   a.cv, a.cb, a.pv, a.x, a.y, a.d, a.fs, a.fd, a.sl,
                   e.cv, e.cb, e.pv, e.x, e.y, e.d, e.fs, e.fd, e.sl);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"},   {31'd0, cmd_valid},   32'd0);
    chk({tag, "_cmd_byte"},    {24'd0, cmd_byte},    32'd0);
    chk({tag, "_pix_valid"},   {31'd0, pix_valid},   32'd0);
    chk({tag, "_pix_x"},       {25'd0, pix_x},       32'd0);
    chk({tag, "_pix_y"},       {24'd0, pix_y},       32'd0);
    chk({tag, "_pix_data"},    {16'd0, pix_data},    32'd0);
    chk({tag, "_frame_start"}, {31'd0, frame_start}, 32'd0);
    chk({tag, "_frame_done"},  {31'd0, frame_done},  32'd0);
    chk({tag, "_sleeping"},    {31'd0, sleeping},    32'd1);
  endtask

  initial begin
    // Asynchronous reset asserted between clock edges
    #23 reset = 1'b1;
    #1 chk_reset_outputs("reset_init");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    cmd(8'h11);
    cmd(8'h2C);
    pix(7'd0, 8'd0, 16'hF800, 1'b0);
    pix(7'd1, 8'd0, 16'h07E0, 1'b0);

    // Window 2..3 x 5..6, wrap and continue into the next frame
    cmd(8'h2A); dat(8'h00); dat(8'h02); dat(8'h00); dat(8'h03);
    cmd(8'h2B); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h06);
    cmd(8'h2C);
    pix(7'd2, 8'd5, 16'h1234, 1'b0);
    pix(7'd3, 8'd5, 16'h5678, 1'b0);
    pix(7'd2, 8'd6, 16'h9ABC, 1'b0);
    pix(7'd3, 8'd6, 16'hDEF0, 1'b1);
    pix(7'd2, 8'd5, 16'h1111, 1'b0);

    // Odd byte then a command: pending high byte dropped
    dat(8'hAA);
    cmd(8'h00);
    cmd(8'h2C);
    pix(7'd2, 8'd5, 16'h2233, 1'b0);

    // Column clamp: 200..250 becomes 127..127
    cmd(8'h2A); dat(8'h00); dat(8'hC8); dat(8'h00); dat(8'hFA);
    cmd(8'h2C);
    pix(7'd127, 8'd5, 16'h0001, 1'b0);
    pix(7'd127, 8'd6, 16'h0002, 1'b1);
    pix(7'd127, 8'd5, 16'h0003, 1'b0);

    // Partial byte aborted by cs, then a full command
    send(1'b0, 8'h10, 5);
    @(negedge clk); cs = 1'b1;
    repeat (6) @(negedge clk);
    cmd(8'h2C);
    pix(7'd127, 8'd5, 16'h4444, 1'b0);

    // SWRESET restores full window and sleep
    cmd(8'h01);
    cmd(8'h2C);
    pix(7'd0, 8'd0, 16'hAAAA, 1'b0);

    // Reset in the middle of a pixel pair
    dat(8'h55);
    send(1'b1, 8'h66, 5);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_reset_outputs("reset_mid");
    sleep_m = 1'b1;
    @(negedge clk); cs = 1'b1; scl = 1'b0; sda = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
